// File: rtl/clint_mmio_slave.sv
// -----------------------------------------------------------------------------
// clint_mmio_slave
//
// Core-local interruptor behind the core's MMIO request bridge. It holds
// mtime, mtimecmp and msip, drives the timer and software interrupt lines,
// and answers every bus access after a fixed, programmable latency.
//
// Parameters:
//   BASE_ADDR : device base address, 64 KiB decode window
//   RESP_LAT  : cycles from request capture to the valid pulse (1..15)
//   TICK_DIV  : clk cycles per mtime increment (>= 1)
//
// Ports:
//   clk, rstn               : clock, asynchronous active-low reset
//   raddr, ren              : read request (ren held until rvalid)
//   rdata, rvalid           : read data (valid only with rvalid), 1-cycle pulse
//   waddr, wen, wdata, wmask: write request (wen held until wvalid), byte enables
//   wvalid                  : 1-cycle write completion pulse
//   timer_irq               : registered (mtime >= mtimecmp), unsigned
//   soft_irq                : registered msip[0]
//
// Optional feature (compile-time macro CLINT_MTIME_WRITE_EN):
//   defined   : mtime is bus-writable per wmask; a bus write beats a
//               same-cycle tick
//   undefined : writes to mtime complete but are dropped
// -----------------------------------------------------------------------------
module clint_mmio_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned RESP_LAT  = 2,
  parameter int unsigned TICK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] raddr,
  input  logic        ren,
  output logic [63:0] rdata,
  output logic        rvalid,
  input  logic [63:0] waddr,
  input  logic        wen,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic        wvalid,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Register offsets expressed as 64-bit word indices (address bits [15:3])
  localparam logic [12:0] OFF_MSIP     = 13'h0000;
  localparam logic [12:0] OFF_MTIMECMP = 13'h0800;
  localparam logic [12:0] OFF_MTIME    = 13'h17FF;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;

  // Bus FSM state and captured request
  state_e      state_q;
  op_e         op_q;
  logic [3:0]  cnt_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        rvalid_q;
  logic        wvalid_q;

  // Architectural registers
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic          timer_irq_q;
  logic          soft_irq_q;

  logic          in_window;
  logic          sel_msip;
  logic          sel_mtimecmp;
  logic          sel_mtime;
  logic          wr_fire;
  logic          tick;
  logic [63:0]   wbit_mask;
  logic          unused_addr_lsbs;

  // ---------------------------------------------------------------------------
  // Bus FSM: IDLE captures a request (write has priority), BUSY counts the
  // latency down, RESP is the single completion cycle. Valid pulses are
  // registered so they coincide exactly with the RESP state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      op_q     <= OP_READ;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rvalid_q <= 1'b0;
          wvalid_q <= 1'b0;
          if (wen) begin
            op_q    <= OP_WRITE;
            addr_q  <= waddr;
            wdata_q <= wdata;
            wmask_q <= wmask;
            cnt_q   <= 4'(RESP_LAT - 1);
            state_q <= BUSY;
          end else if (ren) begin
            op_q    <= OP_READ;
            addr_q  <= raddr;
            cnt_q   <= 4'(RESP_LAT - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q  <= RESP;
            rvalid_q <= (op_q == OP_READ);
            wvalid_q <= (op_q == OP_WRITE);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Requests are not sampled here; a still-held request is picked up
          // by IDLE next cycle as a fresh access.
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          wvalid_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          wvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode on the captured address; bits [2:0] are don't-care since
  // every access is a full 64-bit word.
  // ---------------------------------------------------------------------------
  assign in_window        = (addr_q[63:16] == BASE_ADDR[63:16]);
  assign sel_msip         = in_window && (addr_q[15:3] == OFF_MSIP);
  assign sel_mtimecmp     = in_window && (addr_q[15:3] == OFF_MTIMECMP);
  assign sel_mtime        = in_window && (addr_q[15:3] == OFF_MTIME);
  assign unused_addr_lsbs = ^addr_q[2:0];

  assign wr_fire = (state_q == RESP) && (op_q == OP_WRITE);
  assign tick    = (prescaler_q == PW'(TICK_DIV - 1));

  // Expand byte enables into a bit mask
  for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
    assign wbit_mask[8*gi +: 8] = {8{wmask_q[gi]}};
  end

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
`ifdef CLINT_MTIME_WRITE_EN
    // Bus write overrides the tick; unmasked bytes keep the pre-tick value.
    if (wr_fire && sel_mtime) begin
      mtime_d = (mtime_q & ~wbit_mask) | (wdata_q & wbit_mask);
    end
`endif
    mtimecmp_d = mtimecmp_q;
    if (wr_fire && sel_mtimecmp) begin
      mtimecmp_d = (mtimecmp_q & ~wbit_mask) | (wdata_q & wbit_mask);
    end
    msip_d = msip_q;
    if (wr_fire && sel_msip && wmask_q[0]) begin
      msip_d = wdata_q[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      prescaler_q <= '0;
      timer_irq_q <= 1'b0;
      soft_irq_q  <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      prescaler_q <= prescaler_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      soft_irq_q  <= msip_q;
    end
  end

  // Read data reflects register contents during the RESP cycle itself, so a
  // read of mtime returns the value current in the completion cycle.
  always_comb begin
    rdata = '0;
    if ((state_q == RESP) && (op_q == OP_READ)) begin
      if (sel_msip) begin
        rdata = {63'b0, msip_q};
      end else if (sel_mtimecmp) begin
        rdata = mtimecmp_q;
      end else if (sel_mtime) begin
        rdata = mtime_q;
      end
    end
  end

  assign rvalid    = rvalid_q;
  assign wvalid    = wvalid_q;
  assign timer_irq = timer_irq_q;
  assign soft_irq  = soft_irq_q;

endmodule

// File: tb/tb_clint_mmio_slave.sv
// -----------------------------------------------------------------------------
// tb_clint_mmio_slave
//
// Self-checking bench for clint_mmio_slave with default parameters
// (RESP_LAT=2, TICK_DIV=4). A table of directed bus accesses is applied in a
// loop; latency, pulse shape, timer interrupt timing, simultaneous requests,
// the mtime write option and reset abort are covered by hand sequences.
// cyc counts clock edges since reset release, so mtime is expected to be cyc/4
// until it is written.
// -----------------------------------------------------------------------------
module tb_clint_mmio_slave;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rstn;
  logic [63:0] raddr;
  logic        ren;
  logic [63:0] rdata;
  logic        rvalid;
  logic [63:0] waddr;
  logic        wen;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        wvalid;
  logic        timer_irq;
  logic        soft_irq;

  clint_mmio_slave #(
    .BASE_ADDR(BASE),
    .RESP_LAT (2),
    .TICK_DIV (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .raddr    (raddr),
    .ren      (ren),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .waddr    (waddr),
    .wen      (wen),
    .wdata    (wdata),
    .wmask    (wmask),
    .wvalid   (wvalid),
    .timer_irq(timer_irq),
    .soft_irq (soft_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %-16s got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // One bus access starting in an IDLE cycle; returns latency in cycles and
  // the read data seen on the completion pulse (lat=99 on timeout).
  task automatic bus_access(input bit is_wr, input logic [63:0] addr,
                            input logic [63:0] data, input logic [7:0] mask,
                            output int lat, output logic [63:0] rd);
    @(negedge clk);
    if (is_wr) begin
      wen = 1'b1; waddr = addr; wdata = data; wmask = mask;
    end else begin
      ren = 1'b1; raddr = addr;
    end
    lat = 99;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((is_wr && wvalid) || (!is_wr && rvalid)) begin
        lat = i;
        rd  = rdata;
        break;
      end
    end
    wen = 1'b0;
    ren = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    bit          chk_rd;
    bit          rd_is_mtime;
    logic [63:0] exp_rd;
    bit          exp_soft;
    bit          exp_timer;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [63:0] a, input logic [63:0] d,
                              input logic [7:0] m, input bit c, input bit mt,
                              input logic [63:0] e, input bit s, input bit t);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.mask = m; v.chk_rd = c;
    v.rd_is_mtime = mt; v.exp_rd = e; v.exp_soft = s; v.exp_timer = t;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vecs [NV];

  int          lat;
  logic [63:0] rd;
  logic [63:0] exp_v;
  int unsigned wr_edge;
  int          pulses;

  initial begin
    vecs[0]  = mk(1, BASE,                64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 64'h0, 1, 1);
    vecs[1]  = mk(0, BASE,                64'h0, 8'h00, 1, 0, 64'h1, 1, 1);
    vecs[2]  = mk(1, BASE,                64'h0, 8'hFF, 0, 0, 64'h0, 0, 1);
    vecs[3]  = mk(0, BASE,                64'h0, 8'h00, 1, 0, 64'h0, 0, 1);
    vecs[4]  = mk(1, BASE + 64'h4000,     ONES,  8'hFF, 0, 0, 64'h0, 0, 0);
    vecs[5]  = mk(1, BASE + 64'h4000,     64'h0, 8'h01, 0, 0, 64'h0, 0, 0);
    vecs[6]  = mk(0, BASE + 64'h4000,     64'h0, 8'h00, 1, 0, 64'hFFFF_FFFF_FFFF_FF00, 0, 0);
    vecs[7]  = mk(0, BASE + 64'h1000,     64'h0, 8'h00, 1, 0, 64'h0, 0, 0);
    vecs[8]  = mk(1, BASE + 64'h1000,     64'h55, 8'hFF, 0, 0, 64'h0, 0, 0);
    vecs[9]  = mk(0, BASE + 64'h4000,     64'h0, 8'h00, 1, 0, 64'hFFFF_FFFF_FFFF_FF00, 0, 0);
    vecs[10] = mk(0, 64'h0300_4000,       64'h0, 8'h00, 1, 0, 64'h0, 0, 0);
    vecs[11] = mk(1, 64'h0300_0000,       ONES,  8'hFF, 0, 0, 64'h0, 0, 0);
    vecs[12] = mk(0, BASE,                64'h0, 8'h00, 1, 0, 64'h0, 0, 0);
    vecs[13] = mk(1, BASE,                64'h1, 8'hFE, 0, 0, 64'h0, 0, 0);
    vecs[14] = mk(1, BASE + 64'h4000,     64'h1234, 8'h03, 0, 0, 64'h0, 0, 0);
    vecs[15] = mk(0, BASE + 64'h4007,     64'h0, 8'h00, 1, 0, 64'hFFFF_FFFF_FFFF_1234, 0, 0);
    vecs[16] = mk(0, BASE + 64'hBFF8,     64'h0, 8'h00, 1, 1, 64'h0, 0, 0);

    rstn = 1'b0; ren = 1'b0; wen = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; wmask = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rvalid", {63'b0, rvalid}, 64'h0);
    check("rst_wvalid", {63'b0, wvalid}, 64'h0);
    check("rst_rdata",  rdata, 64'h0);
    check("rst_timer",  {63'b0, timer_irq}, 64'h0);
    check("rst_soft",   {63'b0, soft_irq}, 64'h0);
    rstn = 1'b1;

    // Read latency: ren from cycle 10, pulse in cycle 13 only
    wait_cyc(10);
    ren = 1'b1; raddr = BASE + 64'hBFF8;
    @(negedge clk);
    check("lat_c11_rvalid", {63'b0, rvalid}, 64'h0);
    @(negedge clk);
    check("lat_c12_rvalid", {63'b0, rvalid}, 64'h0);
    @(negedge clk);
    check("lat_c13_rvalid", {63'b0, rvalid}, 64'h1);
    check("lat_c13_mtime",  rdata, 64'(cyc / 4));
    ren = 1'b0;
    @(negedge clk);
    check("lat_c14_rvalid", {63'b0, rvalid}, 64'h0);

    // mtimecmp = 0x20; timer_irq rises at cycle 129
    bus_access(1, BASE + 64'h4000, 64'h20, 8'hFF, lat, rd);
    check("cmp_wr_lat", 64'(lat), 64'd3);
    wait_cyc(127);
    check("timer_c127", {63'b0, timer_irq}, 64'h0);
    @(negedge clk);
    check("timer_c128", {63'b0, timer_irq}, 64'h0);
    @(negedge clk);
    check("timer_c129", {63'b0, timer_irq}, 64'h1);

    // Table of directed accesses
    for (int i = 0; i < NV; i++) begin
      bus_access(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].mask, lat, rd);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'd3);
      if (vecs[i].chk_rd) begin
        exp_v = vecs[i].rd_is_mtime ? 64'(cyc / 4) : vecs[i].exp_rd;
        check($sformatf("v%0d_rdata", i), rd, exp_v);
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_soft", i),  {63'b0, soft_irq},  {63'b0, vecs[i].exp_soft});
      check($sformatf("v%0d_timer", i), {63'b0, timer_irq}, {63'b0, vecs[i].exp_timer});
    end

    // Simultaneous write (msip=1) and read (0x1000): write first
    @(negedge clk);
    wen = 1'b1; waddr = BASE; wdata = 64'h1; wmask = 8'hFF;
    ren = 1'b1; raddr = BASE + 64'h1000;
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (wvalid || rvalid) begin lat = i; break; end
    end
    check("sim_first_lat", 64'(lat), 64'd3);
    check("sim_wvalid",    {63'b0, wvalid}, 64'h1);
    check("sim_rvalid0",   {63'b0, rvalid}, 64'h0);
    wen = 1'b0;
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rvalid) begin lat = i; break; end
    end
    check("sim_rd_gap", 64'(lat), 64'd4);
    check("sim_rdata",  rdata, 64'h0);
    ren = 1'b0;
    check("sim_soft",   {63'b0, soft_irq}, 64'h1);

    // mtime write
`ifdef CLINT_MTIME_WRITE_EN
    bus_access(1, BASE + 64'hBFF8, ONES, 8'hFF, lat, rd);
    wr_edge = cyc + 1;
    check("mt_wr_lat", 64'(lat), 64'd3);
    repeat (4) @(negedge clk);
    bus_access(0, BASE + 64'hBFF8, 64'h0, 8'h00, lat, rd);
    exp_v = ONES + 64'(cyc / 4 - wr_edge / 4);
    check("mt_wrap", rd, exp_v);
`else
    bus_access(1, BASE + 64'hBFF8, 64'h0, 8'hFF, lat, rd);
    check("mt_wr_lat", 64'(lat), 64'd3);
    bus_access(0, BASE + 64'hBFF8, 64'h0, 8'h00, lat, rd);
    check("mt_unchanged", rd, 64'(cyc / 4));
`endif

    // Reset asserted mid-BUSY aborts the access
    @(negedge clk);
    ren = 1'b1; raddr = BASE;
    @(negedge clk);
    rstn = 1'b0;
    ren  = 1'b0;
    #1;
    check("abort_rvalid", {63'b0, rvalid}, 64'h0);
    check("abort_soft",   {63'b0, soft_irq}, 64'h0);
    check("abort_rdata",  rdata, 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rvalid || wvalid) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    bus_access(0, BASE + 64'h4000, 64'h0, 8'h00, lat, rd);
    check("post_rst_cmp", rd, ONES);
    bus_access(0, BASE, 64'h0, 8'h00, lat, rd);
    check("post_rst_msip", rd, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clint_mmio_slave.md
Name: clint_mmio_slave

Overview:
- Memory-mapped core-local interruptor. Sits directly downstream of the core's MMIO request bridge and consumes its slave-side memory handshake (ren/wen held until rvalid/wvalid).
- Holds mtime, mtimecmp and msip; drives the timer and software interrupt lines into the core's CSR/trap logic.
- Each access returns after a programmable fixed latency, so the bridge's stall path is exercised.

Parameters:
- BASE_ADDR, 64'h0200_0000, device base address; decode window is 64 KiB.
- RESP_LAT, 2, cycles from request capture to the valid pulse; legal range 1..15.
- TICK_DIV, 4, clk cycles per mtime increment; must be ≥1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- raddr  in  64  read address
- ren  in  1  read request, held by master until rvalid
- rdata  out  64  read data, valid only while rvalid=1
- rvalid  out  1  one-cycle read completion pulse
- waddr  in  64  write address
- wen  in  1  write request, held by master until wvalid
- wdata  in  64  write data
- wmask  in  8  byte enables; bit i enables wdata[8i+7:8i]
- wvalid  out  1  one-cycle write completion pulse
- timer_irq  out  1  high while mtime ≥ mtimecmp (unsigned compare)
- soft_irq  out  1  equals msip[0]

Behaviour:
- Reset (async, rstn=0) values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - FSM=IDLE, rdata=0, rvalid=0, wvalid=0.
  - timer_irq=0, soft_irq=0.
- Register map, offsets from BASE_ADDR; only address bits [15:3] are decoded and accesses are 64-bit aligned:
  - 0x0000: msip. Only bit 0 is writable; reads return {63'b0, msip}.
  - 0x4000: mtimecmp.
  - 0xBFF8: mtime.
  - Any other offset in the window, or any address outside it: read returns 0, write is dropped, and the access still completes normally.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If wen=1, capture waddr/wdata/wmask, set op=WRITE, load cnt=RESP_LAT-1, go to BUSY.
  - Else if ren=1, capture raddr, set op=READ, go to BUSY.
  - If wen and ren are both high, the write is served first. The read is captured in IDLE after the write's wvalid pulse.
- BUSY: decrement cnt. When cnt=0, go to RESP.
- RESP, one cycle:
  - READ: rvalid=1, rdata holds the register value sampled in this cycle.
  - WRITE: wvalid=1; the register update takes effect at the end of this cycle.
  - Then go to IDLE.
- Request-to-valid latency is RESP_LAT+1 cycles from the first cycle req is high. The minimum legal RESP_LAT (1) gives 2 cycles.
- Requests are not re-sampled in RESP. The cycle after the pulse, IDLE treats a still-high req as a new access; this is a back-to-back access by design.
- Changes to address or data while in BUSY are ignored; the captured copies are used.
- mtime tick:
  - prescaler counts 0..TICK_DIV-1.
  - On wrap, mtime increments by 1, wrapping mod 2^64 from all-ones to 0.
- Same-cycle bus write to mtime and tick: the bus write wins and the increment is lost. Masked bytes keep their pre-increment values.
- timer_irq and soft_irq are registered: they reflect register state one cycle after it changes.
- Async reset asserted mid-transaction aborts the access. No valid pulse is produced after reset release until a new request arrives.

Optional Feature:
- Macro: CLINT_MTIME_WRITE_EN.
- Defined: mtime is writable per wmask, with the collision rule above.
- Undefined:
  - Writes to 0xBFF8 are dropped but still complete with wvalid.
  - mtime is only changed by the tick and by reset.

Test Plan:
- Read mtime, RESP_LAT=2, TICK_DIV=4, ren held from cycle 10 after reset -> rvalid pulses once at cycle 13, for exactly one cycle.
- Write mtimecmp=64'h20 with wmask=8'hFF -> wvalid one pulse. timer_irq rises once mtime reaches 0x20, i.e. 128 clk cycles after reset plus one register cycle.
- Write msip with wdata=64'hFFFF_FFFF_FFFF_FFFF -> soft_irq=1; reading 0x0000 returns 64'h1. Write 0 -> soft_irq=0.
- Partial write to mtimecmp=64'hFFFF..FF with wmask=8'h01, wdata=8'h00 -> readback 64'hFFFF_FFFF_FFFF_FF00.
- ren and wen high together at different addresses -> wvalid fires first. rvalid follows RESP_LAT+1 cycles after the IDLE cycle that follows the wvalid pulse. Read of 0x1000 returns 0.
- CLINT_MTIME_WRITE_EN defined: write mtime=64'hFFFF_FFFF_FFFF_FFFF -> readback wraps to 0 after the next tick.
- CLINT_MTIME_WRITE_EN undefined: the same write leaves mtime unchanged and wvalid still pulses. Deasserting rstn mid-BUSY -> no valid pulse is produced.
